// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// datapath widths and the LSU state encoding.
package mem_lsu_pkg;

   localparam int GPR_WIDTH    = 32;
   localparam int FUNCT3_WIDTH = 3;

   localparam logic [FUNCT3_WIDTH-1:0] F3_B  = 3'b000;
   localparam logic [FUNCT3_WIDTH-1:0] F3_H  = 3'b001;
   localparam logic [FUNCT3_WIDTH-1:0] F3_W  = 3'b010;
   localparam logic [FUNCT3_WIDTH-1:0] F3_BU = 3'b100;
   localparam logic [FUNCT3_WIDTH-1:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the LSU: legality check, byte enables, store lane
// replication and load extract/extend. Purely combinational.
module lsu_align
   import mem_lsu_pkg::*;
#(
   parameter int XLEN = GPR_WIDTH
) (
   input  logic                    re_i,
   input  logic                    we_i,
   input  logic [FUNCT3_WIDTH-1:0] mode_i,
   input  logic [1:0]              off_i,
   input  logic [XLEN-1:0]         wdata_i,
   input  logic [XLEN-1:0]         rdata_i,
   output logic                    legal_o,
   output logic [3:0]              be_o,
   output logic [XLEN-1:0]         wdata_o,
   output logic [XLEN-1:0]         load_o
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      legal_o = 1'b1;
      if (re_i && we_i) begin
         legal_o = 1'b0;
      end
      if (re_i && !(mode_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) begin
         legal_o = 1'b0;
      end
      if (we_i && !(mode_i inside {F3_B, F3_H, F3_W})) begin
         legal_o = 1'b0;
      end
      // size lives in mode[1:0] for both signed and unsigned loads
      if (mode_i[1:0] == 2'b01 && off_i[0]) begin
         legal_o = 1'b0;
      end
      if (mode_i[1:0] == 2'b10 && off_i != 2'b00) begin
         legal_o = 1'b0;
      end
   end

   always_comb begin
      case (mode_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {(XLEN/8){wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << off_i;
            wdata_o = {(XLEN/16){wdata_i[15:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      case (mode_i)
         F3_B:    load_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_H:    load_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_BU:   load_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_HU:   load_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns a pipeline memory request into one data-bus
// transaction, stalls the pipeline until it completes and returns load data.
//
// state | meaning
// IDLE  | waiting for a request; legal request drives the bus immediately
// REQ   | bus request outstanding, waiting for gnt
// WAIT  | load granted, waiting for rvalid
// DONE  | one-cycle completion (done_o, optional err_o); inputs ignored
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int XLEN    = GPR_WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    mem_re_i,
   input  logic                    mem_we_i,
   input  logic [FUNCT3_WIDTH-1:0] mem_mode_i,
   input  logic [XLEN-1:0]         addr_i,
   input  logic [XLEN-1:0]         wdata_i,
   output logic                    dbus_req_o,
   output logic                    dbus_we_o,
   output logic [XLEN-1:0]         dbus_addr_o,
   output logic [3:0]              dbus_be_o,
   output logic [XLEN-1:0]         dbus_wdata_o,
   input  logic                    dbus_gnt_i,
   input  logic                    dbus_rvalid_i,
   input  logic [XLEN-1:0]         dbus_rdata_i,
   output logic [XLEN-1:0]         rdata_o,
   output logic                    done_o,
   output logic                    stall_o,
   output logic                    err_o
);

   localparam int              CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_e      state_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;

   logic            legal;
   logic            req_valid;
   logic            req_ok;
   logic            timeout_hit;
   logic [XLEN-1:0] load_val;

   lsu_align #(.XLEN(XLEN)) u_align (
      .re_i    (mem_re_i),
      .we_i    (mem_we_i),
      .mode_i  (mem_mode_i),
      .off_i   (addr_i[1:0]),
      .wdata_i (wdata_i),
      .rdata_i (dbus_rdata_i),
      .legal_o (legal),
      .be_o    (dbus_be_o),
      .wdata_o (dbus_wdata_o),
      .load_o  (load_val)
   );

   assign req_valid   = mem_re_i | mem_we_i;
   assign req_ok      = req_valid & legal;
   // the count reaches TIMEOUT at the end of this cycle
   assign timeout_hit = (cnt_q == CNT_LAST);

   assign dbus_req_o  = (state_q == LSU_IDLE && req_ok) || (state_q == LSU_REQ);
   assign stall_o     = (state_q == LSU_IDLE && req_ok) || (state_q == LSU_REQ)
                        || (state_q == LSU_WAIT);
   assign dbus_we_o   = mem_we_i;
   assign dbus_addr_o = {addr_i[XLEN-1:2], 2'b00};
   assign rdata_o     = rdata_q;
   assign done_o      = (state_q == LSU_DONE);
   assign err_o       = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LSU_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            LSU_IDLE: begin
               cnt_q <= '0;
               if (req_valid) begin
                  if (!legal) begin
                     state_q <= LSU_DONE;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else if (dbus_gnt_i) begin
                     state_q <= mem_we_i ? LSU_DONE : LSU_WAIT;
                  end else begin
                     state_q <= LSU_REQ;
                  end
               end
            end
            LSU_REQ: begin
               if (dbus_gnt_i) begin
                  state_q <= mem_we_i ? LSU_DONE : LSU_WAIT;
                  cnt_q   <= '0;
               end else if (timeout_hit) begin
                  state_q <= LSU_DONE;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            LSU_WAIT: begin
               if (dbus_rvalid_i) begin
                  state_q <= LSU_DONE;
                  rdata_q <= load_val;
                  cnt_q   <= '0;
               end else if (timeout_hit) begin
                  state_q <= LSU_DONE;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            LSU_DONE: begin
               state_q <= LSU_IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= LSU_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
